// File: rtl/pipe_stage_buffer_pkg.sv
// Shared encodings for the elastic inter-stage buffers (fetch, decode, execute, mem, wb).
// Each state's value is also its occupancy level, so level is just the state cast to two bits.
package pipe_defs;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } buf_state_e;

  function automatic logic [1:0] state_level(input buf_state_e s);
    return 2'(s);
  endfunction

endpackage

// File: rtl/pipe_stage_buffer_sat_counter.sv
// Saturating event counter with a synchronous clear that beats a same-cycle increment.
// Shared by the stage-buffer performance monitors.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_buffer.sv
// Elastic pipeline register: a main register that drives out_data plus one skid entry,
// so back-pressure can stall upstream without dropping data. Flush squashes everything held.
module pipe_stage_buffer
  import pipe_defs::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0,
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       level,
  output logic [CNT_W-1:0] stall_count,
  input  logic             stat_clr
);

  buf_state_e       state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic             in_fire, out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid & out_ready;

  // in_data is only ever sampled under in_fire, so an X payload with in_valid low cannot leak in.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = NOP_VALUE;
      skid_d  = NOP_VALUE;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            skid_d  = in_data;
            state_d = FULL;
          end else if (out_fire) begin
            main_d  = NOP_VALUE;
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_d  = skid_q;
            skid_d  = NOP_VALUE;
            state_d = BUSY;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = NOP_VALUE;
          skid_d  = NOP_VALUE;
        end
      endcase
    end
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      main_q     <= NOP_VALUE;
      skid_q     <= NOP_VALUE;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = in_ready_q;
  assign out_data  = main_q;
  assign level     = state_level(state_q);

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (stat_clr),
    .inc  (out_valid & ~out_ready),
    .count(stall_count)
  );

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Bench for pipe_stage_buffer: a queue-based scoreboard monitor checks ordering, occupancy and
// the stall counter every cycle, while scenario tasks add targeted checks of their own.
module tb_pipe_stage_buffer;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       level;
  logic [CNT_W-1:0] stall_count;
  logic             stat_clr;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] sb_q[$];
  int               cnt_m = 0;

  pipe_stage_buffer #(
    .WIDTH    (WIDTH),
    .NOP_VALUE('0),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .level      (level),
    .stall_count(stall_count),
    .stat_clr   (stat_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard monitor: samples mid-cycle, compares against the queue model, then advances it.
  always @(negedge clk) begin
    logic in_fire_m, out_fire_m;
    if (!rst_n) begin
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || level !== 2'd0 || stall_count !== '0) begin
        bad++;
        $display("[TB] FAIL mon_reset: valid=%b ready=%b level=%0d stall=%0d required 0 1 0 0",
                 out_valid, in_ready, level, stall_count);
      end
      sb_q.delete();
      cnt_m = 0;
    end else begin
      total++;
      if (level !== 2'(sb_q.size()) || out_valid !== (sb_q.size() != 0) ||
          in_ready !== (sb_q.size() != 2)) begin
        bad++;
        $display("[TB] FAIL mon_occupancy: level=%0d valid=%b ready=%b required level=%0d",
                 level, out_valid, in_ready, sb_q.size());
      end
      total++;
      if (stall_count !== 4'(cnt_m)) begin
        bad++;
        $display("[TB] FAIL mon_stall: stall_count=%0d required %0d", stall_count, cnt_m);
      end
      if (sb_q.size() == 0) begin
        total++;
        if (out_data !== '0) begin
          bad++;
          $display("[TB] FAIL mon_nop: out_data=%h required 0", out_data);
        end
      end
      in_fire_m  = in_valid && (sb_q.size() < 2);
      out_fire_m = (sb_q.size() > 0) && out_ready;
      if (out_fire_m) begin
        total++;
        if (out_data !== sb_q[0]) begin
          bad++;
          $display("[TB] FAIL mon_order: out_data=%h required %h", out_data, sb_q[0]);
        end
        void'(sb_q.pop_front());
      end
      if (flush) begin
        sb_q.delete();
      end else if (in_fire_m) begin
        sb_q.push_back(in_data);
      end
      if (stat_clr) begin
        cnt_m = 0;
      end else if (out_valid === 1'b1 && !out_ready && cnt_m < 15) begin
        cnt_m++;
      end
    end
  end

  // Presents one cycle of inputs, lets the rising edge take them, then returns just after it.
  task automatic applyStimulus(input logic iv, input logic [WIDTH-1:0] id, input logic ordy,
                               input logic fl, input logic clr);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    stat_clr  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0 || level !== 2'd0) begin
      bad++;
      $display("[TB] FAIL reset_values: valid=%b ready=%b data=%h level=%0d required 0 1 0 0",
               out_valid, in_ready, out_data, level);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_streaming;
    logic [WIDTH-1:0] w;
    for (int i = 1; i <= 8; i++) begin
      w = 32'hA000_0000 + 32'(i);
      applyStimulus(1'b1, w, 1'b1, 1'b0, 1'b0);
      total++;
      if (out_valid !== 1'b1 || out_data !== w || level !== 2'd1) begin
        bad++;
        $display("[TB] FAIL stream_%0d: valid=%b data=%h level=%0d required 1 %h 1",
                 i, out_valid, out_data, level, w);
      end
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    total++;
    if (out_valid !== 1'b0 || level !== 2'd0) begin
      bad++;
      $display("[TB] FAIL stream_drain: valid=%b level=%0d required 0 0", out_valid, level);
    end
  endtask

  task automatic test_backpressure;
    applyStimulus(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
    total++;
    if (level !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'h11) begin
      bad++;
      $display("[TB] FAIL bp_full: level=%0d ready=%b data=%h required 2 0 11",
               level, in_ready, out_data);
    end
    applyStimulus(1'b1, 32'h33, 1'b0, 1'b0, 1'b0);
    total++;
    if (level !== 2'd2 || out_data !== 32'h11) begin
      bad++;
      $display("[TB] FAIL bp_hold: level=%0d data=%h required 2 11", level, out_data);
    end
    applyStimulus(1'b1, 32'h33, 1'b1, 1'b0, 1'b0);
    total++;
    if (out_data !== 32'h22 || out_valid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL bp_second: data=%h valid=%b required 22 1", out_data, out_valid);
    end
    applyStimulus(1'b1, 32'h33, 1'b1, 1'b0, 1'b0);
    total++;
    if (out_data !== 32'h33 || out_valid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL bp_third: data=%h valid=%b required 33 1", out_data, out_valid);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_flush_full;
    applyStimulus(1'b1, 32'h44, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h66, 1'b0, 1'b1, 1'b0);
    total++;
    if (level !== 2'd0 || out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL flush_full: level=%0d valid=%b data=%h ready=%b required 0 0 0 1",
               level, out_valid, out_data, in_ready);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL flush_ghost: valid=%b data=%h required valid 0", out_valid, out_data);
    end
  endtask

  task automatic test_stall_saturation;
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h99, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
      if (k == 14 || k == 15 || k == 20) begin
        total++;
        if (stall_count !== 4'((k < 15) ? k : 15)) begin
          bad++;
          $display("[TB] FAIL stall_sat_%0d: stall_count=%0d required %0d",
                   k, stall_count, (k < 15) ? k : 15);
        end
      end
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    total++;
    if (stall_count !== 4'd0) begin
      bad++;
      $display("[TB] FAIL stall_clr: stall_count=%0d required 0", stall_count);
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    total++;
    if (stall_count !== 4'd2) begin
      bad++;
      $display("[TB] FAIL stall_resume: stall_count=%0d required 2", stall_count);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_simultaneous;
    applyStimulus(1'b1, 32'h77, 1'b1, 1'b0, 1'b0);
    total++;
    if (out_data !== 32'h77 || level !== 2'd1) begin
      bad++;
      $display("[TB] FAIL simul_load: data=%h level=%0d required 77 1", out_data, level);
    end
    applyStimulus(1'b1, 32'h88, 1'b1, 1'b0, 1'b0);
    total++;
    if (out_data !== 32'h88 || level !== 2'd1) begin
      bad++;
      $display("[TB] FAIL simul_swap: data=%h level=%0d required 88 1", out_data, level);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset;
    applyStimulus(1'b1, 32'hAA, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hBB, 1'b0, 1'b0, 1'b0);
    total++;
    if (level !== 2'd2) begin
      bad++;
      $display("[TB] FAIL areset_fill: level=%0d required 2", level);
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0 || level !== 2'd0 ||
        stall_count !== '0) begin
      bad++;
      $display("[TB] FAIL areset_async: valid=%b ready=%b data=%h level=%0d stall=%0d required 0 1 0 0 0",
               out_valid, in_ready, out_data, level, stall_count);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    applyStimulus(1'b1, 32'hCC, 1'b1, 1'b0, 1'b0);
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'hCC) begin
      bad++;
      $display("[TB] FAIL areset_first: valid=%b data=%h required 1 cc", out_valid, out_data);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    stat_clr  = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_full();
    test_stall_saturation();
    test_simultaneous();
    test_async_reset();
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buffer.md
Name: pipe_stage_buffer

Overview:
Parametrised elastic pipeline register that replaces the fixed, always-loading inter-stage buffers between the ALU, memory and writeback stages. It carries one WIDTH-bit packed payload per transfer with a valid/ready handshake on each side. A one-entry skid register lets back-pressure stall upstream without losing data. A flush input inserts bubbles (NOP_VALUE) on branch or jump redirect, and a saturating counter records downstream stall cycles for performance monitoring.

Parameters:
WIDTH, 32, payload width in bits (packed stage fields); legal range 1..256
NOP_VALUE, {WIDTH{1'b0}}, payload driven on out_data while empty, after flush and after reset
CNT_W, 16, width of stall_count

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous squash of all held entries
in_valid  input  1  upstream payload valid
in_ready  output  1  buffer can accept; registered
in_data  input  WIDTH  upstream payload
out_valid  output  1  payload available downstream
out_ready  input  1  downstream accepts
out_data  output  WIDTH  payload to next stage; registered
level  output  2  occupancy: 0, 1 or 2 entries
stall_count  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0
stat_clr  input  1  synchronous clear of stall_count

Behaviour:
- Handshake events: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Transfers happen only on a fire. in_data is ignored unless in_fire. in_valid may drop without a fire.
- Registers: main (drives out_data), skid, state.
- States: EMPTY (level 0), BUSY (level 1), FULL (level 2).
- Async reset (rst_n=0), held until release:
  - state=EMPTY, main=skid=NOP_VALUE.
  - out_valid=0, in_ready=1, level=0, stall_count=0.
- Derived outputs:
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL), registered from next-state.
  - out_data = main.
- Transitions (no flush):
  - EMPTY, in_fire: main<=in_data; go BUSY.
  - BUSY, in_fire & !out_fire: skid<=in_data; go FULL.
  - BUSY, in_fire & out_fire: main<=in_data; stay BUSY.
  - BUSY, out_fire & !in_fire: main<=NOP_VALUE; go EMPTY.
  - FULL, out_fire: main<=skid, skid<=NOP_VALUE; go BUSY. in_fire is impossible in FULL.
  - Any other case: hold all registers.
- Latency and ordering:
  - Latency: in_fire in cycle N gives out_valid=1 with that payload in cycle N+1.
  - Sustained throughput: 1 transfer per cycle while out_ready=1.
  - Order is strictly FIFO; no payload is duplicated or dropped except by flush.
- Flush (highest priority, synchronous):
  - Next state EMPTY; main and skid <= NOP_VALUE.
  - A same-cycle in_fire is discarded.
  - A same-cycle out_fire still counts as consumed downstream.
  - in_ready=1 the following cycle.
  - stall_count is unaffected.
- stall_count:
  - Increments by 1 in each cycle where out_valid & !out_ready.
  - Saturates at 2^CNT_W-1 with no wrap.
  - stat_clr has priority: a same-cycle increment is lost and the count becomes 0.
- Reset asserted mid-transfer: immediately returns to the reset values; in-flight payloads are lost.
- X-safety: no state update may depend on in_data when in_valid=0.

Decomposition:
- Shared package pipe_defs: state encodings EMPTY=2'd0, BUSY=2'd1, FULL=2'd2 and the level encoding (equal to the state value). The fetch, decode and execute buffers reuse it.
- One sub-module: sat_counter (parameter WIDTH; ports clk, rst_n, clr, inc, count). It is instantiated for stall_count and reused by other stage buffers' monitors.

Test Plan (WIDTH=32, CNT_W=4, NOP_VALUE=0):
1. Reset and streaming:
   - Stimulus: rst_n low for 3 cycles, then release; out_ready=1; push 0xA0000001..0xA0000008 on consecutive cycles.
   - Required: during reset out_valid=0, in_ready=1, out_data=0. Each word appears one cycle after acceptance, in order; level never exceeds 1.
2. Back-pressure fill:
   - Stimulus: out_ready=0; push 0x11, 0x22, 0x33 on consecutive cycles.
   - Required: 0x11 and 0x22 accepted; level=2, in_ready=0; 0x33 held upstream.
   - Then out_ready=1: outputs 0x11, 0x22, 0x33 in consecutive cycles with no gap.
3. Flush while FULL:
   - Stimulus: state FULL holding 0x44 and 0x55; assert flush together with in_valid=1 and in_data=0x66.
   - Required next cycle: level=0, out_valid=0, out_data=0, in_ready=1; 0x66 never appears.
4. Stall counter saturation and clear:
   - Stimulus: hold out_valid=1, out_ready=0 for 20 cycles.
   - Required: stall_count reaches 15 and stays at 15.
   - Then pulse stat_clr in a stall cycle: count=0 next cycle, then resumes 1, 2, …
5. Simultaneous in/out while BUSY:
   - Stimulus: in state BUSY with main=0x77, in_fire with 0x88 and out_fire in the same cycle.
   - Required: 0x77 consumed; next cycle out_data=0x88, level=1.
6. Async reset mid-operation:
   - Stimulus: drop rst_n between clock edges while FULL.
   - Required: outputs reach reset values without waiting for a clock edge; first push after release is output with 1-cycle latency.
